// File: rtl/forward_ctrl.sv
// ---------------------------------------------------------------------------
// forward_ctrl
//   Forwarding / load-use hazard controller for a classic 5-stage pipeline.
//   Tracks the destination register of the instructions currently in EX and
//   MEM. When an instruction moves from ID to EX, it registers one 2-bit
//   operand-mux select per source into EX alongside that instruction:
//     00 = register-file data, 01 = EX/MEM result, 10 = MEM/WB result.
//   A load in EX whose result is needed by the ID instruction raises a
//   combinational stall. The stall holds PC and IF/ID for one cycle and
//   injects a bubble into EX.
//
//   Handshake: there is no valid/ready pair. id_valid qualifies every id_*
//   field. stall is the only back-pressure signal: while it is high, the
//   instruction in ID is held upstream and a bubble enters EX. flush drops
//   the ID instruction.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   id_valid        ID holds a real instruction
//   id_rs, id_rt    ID source register indices (rt used only if id_use_rt)
//   id_use_rt       ID instruction reads rt
//   id_rd, id_wr_en ID destination index and write enable
//   id_is_load      ID instruction is a load
//   flush           branch flush; ID instruction must not enter EX
//   fwd_sel_a/b     registered EX operand mux selects
//   stall           hold PC and IF/ID this cycle (combinational)
//   stall_cnt       saturating count of stalled cycles since reset
// ---------------------------------------------------------------------------
module forward_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  id_rs,
    input  logic [REG_ADDR_W-1:0]  id_rt,
    input  logic                   id_use_rt,
    input  logic [REG_ADDR_W-1:0]  id_rd,
    input  logic                   id_wr_en,
    input  logic                   id_is_load,
    input  logic                   flush,
    output logic [1:0]             fwd_sel_a,
    output logic [1:0]             fwd_sel_b,
    output logic                   stall,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] SEL_DATA = 2'b00;
    localparam logic [1:0] SEL_EX   = 2'b01;
    localparam logic [1:0] SEL_MEM  = 2'b10;

    // Instruction now in EX
    logic                   r_ex_v;
    logic [REG_ADDR_W-1:0]  r_ex_rd;
    logic                   r_ex_wr;
    logic                   r_ex_ld;
    // Instruction now in MEM
    logic                   r_mem_v;
    logic [REG_ADDR_W-1:0]  r_mem_rd;
    logic                   r_mem_wr;

    logic [1:0]             r_sel_a;
    logic [1:0]             r_sel_b;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic                   w_stall;
    logic                   w_advance;
    logic                   w_ex_hit_a;
    logic                   w_ex_hit_b;
    logic                   w_mem_hit_a;
    logic                   w_mem_hit_b;
    logic [1:0]             w_sel_a;
    logic [1:0]             w_sel_b;

    // A stage writer supplies source s only for a nonzero register. r0 is hardwired.
    function automatic logic hits(input logic v, input logic wr,
                                  input logic [REG_ADDR_W-1:0] rd,
                                  input logic [REG_ADDR_W-1:0] s);
        return v && wr && (rd == s) && (s != '0);
    endfunction

    always_comb begin
        w_ex_hit_a  = hits(r_ex_v,  r_ex_wr,  r_ex_rd,  id_rs);
        w_ex_hit_b  = id_use_rt && hits(r_ex_v, r_ex_wr, r_ex_rd, id_rt);
        w_mem_hit_a = hits(r_mem_v, r_mem_wr, r_mem_rd, id_rs);
        w_mem_hit_b = id_use_rt && hits(r_mem_v, r_mem_wr, r_mem_rd, id_rt);

        // Load result is not ready until MEM, so a dependent op must wait one
        // cycle. flush wins: a flushed instruction never needs its operands.
        w_stall = id_valid && !flush && r_ex_ld && (w_ex_hit_a || w_ex_hit_b);

        w_advance = id_valid && !flush && !w_stall;

        // The current EX writer sits in EX/MEM next cycle, and the current MEM
        // writer sits in MEM/WB. The younger writer takes priority.
        w_sel_a = SEL_DATA;
        if (w_ex_hit_a)       w_sel_a = SEL_EX;
        else if (w_mem_hit_a) w_sel_a = SEL_MEM;

        w_sel_b = SEL_DATA;
        if (w_ex_hit_b)       w_sel_b = SEL_EX;
        else if (w_mem_hit_b) w_sel_b = SEL_MEM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_v      <= 1'b0;
            r_ex_rd     <= '0;
            r_ex_wr     <= 1'b0;
            r_ex_ld     <= 1'b0;
            r_mem_v     <= 1'b0;
            r_mem_rd    <= '0;
            r_mem_wr    <= 1'b0;
            r_sel_a     <= SEL_DATA;
            r_sel_b     <= SEL_DATA;
            r_stall_cnt <= '0;
        end else begin
            // MEM never stalls.
            r_mem_v  <= r_ex_v;
            r_mem_rd <= r_ex_rd;
            r_mem_wr <= r_ex_wr;

            if (w_advance) begin
                r_ex_v  <= 1'b1;
                r_ex_rd <= id_rd;
                r_ex_wr <= id_wr_en;
                r_ex_ld <= id_is_load;
                r_sel_a <= w_sel_a;
                r_sel_b <= w_sel_b;
            end else begin
                r_ex_v  <= 1'b0;
                r_ex_rd <= '0;
                r_ex_wr <= 1'b0;
                r_ex_ld <= 1'b0;
                r_sel_a <= SEL_DATA;
                r_sel_b <= SEL_DATA;
            end

            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign fwd_sel_a = r_sel_a;
    assign fwd_sel_b = r_sel_b;
    assign stall     = w_stall;
    assign stall_cnt = r_stall_cnt;

endmodule
